// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional FORWARD_EN build narrows hazards to load-use only.
package hazard_ctrl_pkg;

  localparam int NUM_SLOTS = 3;
  localparam int REG_AW    = 3;
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wreg;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/hazard_cmp.sv
// Matches one ID source register against the in-flight write slots.
// With FORWARD_EN only a load still in EX can block the reader.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic                  uses,
  input  logic [REG_AW-1:0]     src,
  input  slot_t [NUM_SLOTS-1:0] slots,
  output logic                  hit
);

`ifdef FORWARD_EN
  always_comb begin
    hit = uses
        & slots[0].valid
        & slots[0].is_load
        & (slots[0].wreg == src);
  end
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (uses && slots[i].valid && slots[i].wreg == src)
        hit = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush/freeze sequencing for the 5-stage core plus halt drain.
// Define FORWARD_EN when the datapath has EX/MEM/WB forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rd1_sel,
  input  logic [REG_AW-1:0] id_rd2_sel,
  input  logic              id_uses_r1,
  input  logic              id_uses_r2,
  input  logic              id_reg_wrt,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_load,
  input  logic              id_halt,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_ifid,
  output logic              freeze,
  output logic              halted,
  output logic              err
);

  slot_t [NUM_SLOTS-1:0] slots;
  slot_t                 slot_new;
  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  hit1, hit2;
  logic                  hazard, run, issuing, err_set;

  hazard_cmp u_cmp1 (
    .uses  (id_uses_r1),
    .src   (id_rd1_sel),
    .slots (slots),
    .hit   (hit1)
  );

  hazard_cmp u_cmp2 (
    .uses  (id_uses_r2),
    .src   (id_rd2_sel),
    .slots (slots),
    .hit   (hit2)
  );

  assign run     = (state == RUN);
  assign hazard  = id_valid & (hit1 | hit2);
  assign issuing = id_valid & ~hazard & ~br_taken
                 & run & ~mem_busy;
  assign err_set = (br_taken & ~run)
                 | (id_valid & id_reg_wrt & id_halt);

  always_comb begin
    slot_new = '0;
    if (issuing && id_reg_wrt) begin
      slot_new.valid   = 1'b1;
      slot_new.wreg    = id_wr_reg;
      slot_new.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      if (!mem_busy)
        slots <= {slots[NUM_SLOTS-2:0], slot_new};
      state <= state_nx;
      cnt   <= cnt_nx;
      if (err_set)
        err <= 1'b1;
    end
  end

  // A frozen pipe holds both the FSM and the drain counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!mem_busy) begin
      unique case (state)
        RUN: begin
          if (issuing && id_halt) begin
            state_nx = DRAIN;
            cnt_nx   = CNT_W'(NUM_SLOTS);
          end
        end
        DRAIN: begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state_nx = HALTED;
        end
        HALTED: ;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    stall_if   = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    freeze     = 1'b0;
    halted     = (state == HALTED);
    unique case (1'b1)
      mem_busy: begin
        freeze   = 1'b1;
        stall_if = 1'b1;
      end
      (!mem_busy && !run): begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
      (!mem_busy && run && br_taken): begin
        flush_ifid = 1'b1;
        bubble_ex  = 1'b1;
      end
      (!mem_busy && run && !br_taken && hazard): begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Tracks in-flight register writes in a scoreboard. Generates fetch/decode stalls and ID/EX bubbles on RAW hazards, and flushes wrong-path instructions on a taken branch or jump.
- Runs the halt drain sequence.
- Sits beside the decode stage and drives the enables/clears of the IF/ID and ID/EX pipeline flops.

Parameters:
- NUM_SLOTS, 3, in-flight stages tracked: slot0 = EX, slot1 = MEM, slot2 = WB.
- REG_AW, 3, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rd1_sel  in  REG_AW  ID source register 1
- id_rd2_sel  in  REG_AW  ID source register 2
- id_uses_r1  in  1  ID reads source 1
- id_uses_r2  in  1  ID reads source 2
- id_reg_wrt  in  1  ID instruction writes the register file
- id_wr_reg  in  REG_AW  ID destination register
- id_is_load  in  1  ID instruction is a load (memToReg)
- id_halt  in  1  ID instruction is HALT
- br_taken  in  1  EX resolved a taken branch or jump this cycle
- mem_busy  in  1  data memory not ready; freeze the whole pipe
- stall_if  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- flush_ifid  out  1  clear IF/ID
- freeze  out  1  hold all pipeline flops
- halted  out  1  core halted
- err  out  1  protocol error, sticky

Behaviour:
- Reset: all slots invalid; FSM = RUN; all outputs 0.
- Slot contents: {valid, reg, is_load}.
- Issue: ID issues when id_valid & ~hazard & ~br_taken & state==RUN & ~mem_busy.
- Scoreboard advance (every cycle unless mem_busy):
  - slot2 <= slot1; slot1 <= slot0.
  - slot0 <= issuing & id_reg_wrt ? {1, id_wr_reg, id_is_load} : invalid.
- mem_busy:
  - freeze = 1, stall_if = 1, bubble_ex = 0, flush_ifid = 0.
  - Scoreboard and FSM hold.
  - br_taken is ignored that cycle; EX holds it and re-asserts it.
- Hazard (combinational, no forwarding): (id_uses_r1 & rd1 matches a valid slot) | (id_uses_r2 & rd2 matches a valid slot).
  - Response: stall_if = 1 and bubble_ex = 1 the same cycle.
  - Latency: a hazard is resolved at most NUM_SLOTS cycles after producer issue.
  - Slot2 counts as a hazard: the RF has no write-before-read bypass.
- br_taken (priority over hazard and halt):
  - flush_ifid = 1, bubble_ex = 1, stall_if = 0.
  - The ID instruction is not recorded in slot0.
- FSM:
  - RUN: id_halt & issuing -> DRAIN. A halt flushed by br_taken stays in RUN.
  - DRAIN:
    - stall_if = 1, bubble_ex = 1.
    - Down-counter loaded with NUM_SLOTS on entry; decrements on non-frozen cycles.
    - 0 -> HALTED.
  - HALTED: halted = 1, stall_if = 1, bubble_ex = 1 until rst.
- err is set sticky when:
  - br_taken is asserted in DRAIN or HALTED, or
  - id_valid & id_reg_wrt & id_halt.
- rst mid-DRAIN or mid-stall: everything returns to reset state next edge.

Optional Feature:
- FORWARD_EN:
  - Defined: EX/MEM/WB forwarding exists. Hazard reduces to load-use only: slot0 valid & slot0.is_load & source match. Gives a 1-cycle bubble.
  - Undefined: full scoreboard compare as above.

Decomposition:
- Shared package:
  - FSM state encoding: RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2.
  - Scoreboard slot struct {valid, reg[REG_AW-1:0], is_load}.
  - NUM_SLOTS constant.
- Sub-module hazard_cmp: compares one source against all slots; instanced twice.

Test Plan:
- ADD r3 issues, then ID reads r3 (no FORWARD_EN) -> stall_if = bubble_ex = 1 for 3 cycles; dependent issues on cycle 4.
- Same with FORWARD_EN, producer is LD r3 -> exactly 1 bubble. Non-load producer -> 0 bubbles.
- br_taken while ID has a hazard and id_halt = 1 -> flush_ifid = 1, no slot0 entry, FSM stays RUN, no stall.
- HALT issues with 2 writers in flight -> DRAIN for 3 unfrozen cycles, then halted = 1 and holds.
- mem_busy for 4 cycles during a hazard -> freeze = 1, scoreboard unchanged; stall count resumes after release.
- rst asserted mid-DRAIN -> next cycle state RUN, slots empty, halted = 0, err = 0.
